spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI slave endpoint on the far side of the SPI link from spi_master; consumes sclk/mosi/slave_sel and returns miso/slave_ready.
- Oversamples the SPI pins on its own system clock.
- Deserialises received words into a one-entry RX buffer with a valid/ready handshake toward the I2C-side command logic.
- Serialises a word supplied through a one-entry TX buffer back to the master in the same transfer.

Parameters:
- WIDTH, 8: SPI word width in bits.
- CT, $clog2(WIDTH): bit counter width. Derived; not overridden.

Ports:
- slave_clk_i  in  1  system clock; must run at ≥4× the SCLK frequency.
- reset_i  in  1  synchronous, active-high reset.
- sclk_i  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- mosi_i  in  1  serial data from master, MSB first.
- slave_sel_i  in  1  chip select from master, active low.
- miso_o  out  1  serial data to master, MSB first.
- slave_ready_o  out  1  high when the slave can accept a new transfer.
- rx_data_o  out  WIDTH  last complete received word.
- rx_valid_o  out  1  rx_data_o holds an unconsumed word.
- rx_ready_i  in  1  downstream accepts rx_data_o.
- tx_data_i  in  WIDTH  word to return on the next transfer.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  TX buffer empty and able to accept a word.
- overrun_o  out  1  one-cycle pulse: a completed word was dropped because the RX buffer was full.
- abort_o  out  1  one-cycle pulse: slave_sel deasserted mid-word.

Behaviour:
- Reset values (synchronous, reset_i high on a slave_clk_i edge):
  - miso_o=0, slave_ready_o=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, overrun_o=0, abort_o=0.
  - State=IDLE, bit counter=0.
  - Synchroniser flops reset to idle levels: sclk=0, sel=1, mosi=0.
- Input sampling:
  - sclk_i, mosi_i and slave_sel_i each pass through a 2-flop synchroniser, plus one extra flop for edge detection.
  - rise/fall/sel_assert/sel_deassert are single-cycle strobes, 3 cycles after the pin edge.
- TX buffer:
  - tx_valid_i && tx_ready_o loads the shadow register and clears tx_ready_o.
  - The buffer is consumed at sel_assert.
  - If the buffer is empty at sel_assert, the shift register loads all-zeros.
  - tx_ready_o returns high the cycle after consumption.
- State machine:
  - IDLE: miso_o=0. On sel_assert: load the TX shift register from the buffer and drive its MSB on miso_o; counter=0; go to SHIFT.
  - SHIFT, on rise: shift the synchronised mosi into the RX shift register LSB; counter++.
  - SHIFT, on fall with counter!=0: shift TX left; miso_o = new MSB.
  - SHIFT, when counter reaches WIDTH after a rise: go to DONE in the same cycle.
  - SHIFT, on sel_deassert before WIDTH bits: discard the partial word, pulse abort_o, go to IDLE.
  - DONE, RX buffer empty (or rx_ready_i high that same cycle): transfer the word to rx_data_o and set rx_valid_o.
  - DONE, RX buffer otherwise full: drop the word, keep the old rx_data_o, pulse overrun_o.
  - DONE, next cycle: if sel is still asserted, go to SHIFT with the TX reloaded as on sel_assert (back-to-back words within one select). Otherwise go to IDLE.
- RX handshake:
  - rx_valid_o && rx_ready_i clears rx_valid_o next cycle.
  - rx_data_o holds its value until replaced.
  - Simultaneous consume and new-word load: the new word wins and rx_valid_o stays 1.
- slave_ready_o = (state==IDLE) && !rx_valid_o && !sel_synced_active. Registered, one cycle late.
- Glitch rule: sclk edges while sel is inactive are ignored.
- Reset mid-transfer: any word in progress is discarded with no abort_o pulse, and miso_o returns to 0.
- Latency: the final sclk rise to rx_valid_o high is 4 slave_clk_i cycles.

Decomposition:
- spi_pkg holds:
  - localparams SPI_MODE0, SEL_ACTIVE=1'b0, SYNC_STAGES=2.
  - State encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- Sub-module spi_sync_edge: parameterised 2-flop synchroniser plus edge detector. It outputs the level and rise/fall strobes and is instantiated three times.
- The shift/FSM/buffer logic stays in spi_slave.

Test Plan:
- Basic duplex: tx_data_i=8'hA5 loaded, master sends 8'h3C with SCLK = clk/8. Required: master receives 8'hA5; rx_data_o=8'h3C; rx_valid_o rises 4 cycles after the 8th rise.
- Back-to-back: sel held low for 16 bits carrying 8'h01, 8'h02, with rx_ready_i=1. Required: two rx_valid_o events with 8'h01 then 8'h02; no overrun_o.
- Overrun: rx_ready_i=0, two transfers 8'h11 then 8'h22. Required: rx_data_o stays 8'h11; overrun_o pulses exactly once; slave_ready_o stays low.
- Abort: sel deasserted after 5 bits. Required: abort_o pulses once; rx_valid_o remains 0; state returns to IDLE; the next full transfer 8'hF0 is received correctly.
- Empty TX: no tx_valid_i before the transfer. Required: master receives 8'h00; tx_ready_o stays 1.
- Reset mid-transfer: reset_i pulsed after 3 bits. Required: all outputs at reset values the next cycle; no abort_o pulse; the subsequent transfer 8'h5A completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: bus mode, select polarity, synchroniser depth
// and the transfer state encoding.
package spi_pkg;

  localparam logic [1:0]  SPI_MODE0   = 2'b00;  // {CPOL, CPHA}
  localparam logic        SEL_ACTIVE  = 1'b0;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an extra flop
// that turns level changes into single-cycle rise/fall strobes.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES    = SYNC_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    edge_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      edge_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~edge_q;
  assign fall_o  = ~sync_q[STAGES-1] & edge_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave oversampled on slave_clk_i: one-entry RX buffer with
// valid/ready toward the command logic, one-entry TX buffer returned per word.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CT    = $clog2(WIDTH)
) (
  input  logic             slave_clk_i,
  input  logic             reset_i,
  input  logic             sclk_i,
  input  logic             mosi_i,
  input  logic             slave_sel_i,
  output logic             miso_o,
  output logic             slave_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             overrun_o,
  output logic             abort_o
);

  logic sclk_lvl, sclk_rise_raw, sclk_fall_raw;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sel_lvl, sel_rise, sel_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(slave_clk_i), .rst_i(reset_i), .d_i(sclk_i),
    .level_o(sclk_lvl), .rise_o(sclk_rise_raw), .fall_o(sclk_fall_raw)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk_i(slave_clk_i), .rst_i(reset_i), .d_i(mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(~SEL_ACTIVE)) u_sel_sync (
    .clk_i(slave_clk_i), .rst_i(reset_i), .d_i(slave_sel_i),
    .level_o(sel_lvl), .rise_o(sel_rise), .fall_o(sel_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  logic sel_active, sel_assert, sel_deassert, sclk_rise, sclk_fall;
  assign sel_active   = (sel_lvl == SEL_ACTIVE);
  assign sel_assert   = (SEL_ACTIVE == 1'b0) ? sel_fall : sel_rise;
  assign sel_deassert = (SEL_ACTIVE == 1'b0) ? sel_rise : sel_fall;
  assign sclk_rise    = sclk_rise_raw & sel_active;
  assign sclk_fall    = sclk_fall_raw & sel_active;

  spi_state_e       state_q, state_d;
  logic [CT-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic             rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic             miso_q, miso_d, slave_ready_q, slave_ready_d;
  logic             overrun_q, overrun_d, abort_q, abort_d;
  logic             load_tx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    overrun_d  = 1'b0;
    abort_d    = 1'b0;
    load_tx    = 1'b0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (sel_assert) begin
          load_tx = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sel_deassert) begin
          // A zero-bit word (select released right after a completed word) is not a partial word.
          abort_d = (cnt_q != '0);
          miso_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_lvl};
          cnt_d   = cnt_q + CT'(1);
          if (cnt_q == CT'(WIDTH - 1)) state_d = DONE;
        end else if (sclk_fall && cnt_q != '0) begin
          tx_sh_d = tx_sh_q << 1;
          miso_d  = tx_sh_q[WIDTH-2];
        end
      end
      DONE: begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (sel_active) begin
          load_tx = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_tx) begin
      tx_sh_d    = tx_ready_q ? '0 : tx_buf_q;
      miso_d     = tx_sh_d[WIDTH-1];
      tx_ready_d = 1'b1;
    end
    if (tx_valid_i && tx_ready_q) begin
      tx_buf_d   = tx_data_i;
      tx_ready_d = 1'b0;
    end

    slave_ready_d = (state_q == IDLE) && !rx_valid_q && !sel_active;
  end

  always_ff @(posedge slave_clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      slave_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      slave_ready_q <= slave_ready_d;
      overrun_q     <= overrun_d;
      abort_q       <= abort_d;
    end
  end

  assign miso_o        = miso_q;
  assign slave_ready_o = slave_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = tx_ready_q;
  assign overrun_o     = overrun_q;
  assign abort_o       = abort_q;

endmodule
